// File: rtl/sm2201_bus_cycle_initiator.sv
// Host-side initiator for SM2201 board bus cycles toward micro_program_automate.
// It accepts one command at a time, strobes sel with setup/hold spacing and returns a one-cycle response.
module sm2201_bus_cycle_initiator #(
  parameter int DATA_WIDTH     = 16,
  parameter int SETUP_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_a,
  input  logic                  cmd_w,
  input  logic                  cmd_tim,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic                  cfg_ie,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_x0,
  output logic                  rsp_x1,
  output logic                  rsp_timeout,
  output logic [1:0]            a,
  output logic                  w,
  output logic                  sel,
  output logic                  tim,
  output logic                  ie,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  d_oe,
  input  logic                  rdy,
  input  logic                  x0,
  input  logic                  x1,
  input  logic [DATA_WIDTH-1:0] d_in
);

  localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, capture, timeout_hit, exit_release;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    accept       = 1'b0;
    capture      = 1'b0;
    timeout_hit  = 1'b0;
    exit_release = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = S_SETUP;
          cnt_nxt   = SETUP_LOAD;
        end
      end
      S_SETUP: begin
        if (cnt == '0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      // rdy wins over the timeout on the last strobe clock
      S_STROBE: begin
        if (rdy) begin
          capture   = 1'b1;
          state_nxt = S_RELEASE;
          cnt_nxt   = '0;
        end else if (cnt >= TO_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = S_RELEASE;
          cnt_nxt     = '0;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      S_RELEASE: begin
        if ((cnt >= HOLD_LAST) && !rdy) begin
          exit_release = 1'b1;
          state_nxt    = S_RESP;
        end else if (cnt >= TO_LAST) begin
          timeout_hit  = 1'b1;
          exit_release = 1'b1;
          state_nxt    = S_RESP;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign sel       = (state == S_STROBE);
  assign rsp_valid = (state == S_RESP);

  // Bus fields and response are held between commands; only an accept reloads them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a           <= '0;
      w           <= 1'b0;
      tim         <= 1'b0;
      ie          <= 1'b0;
      d_out       <= '0;
      d_oe        <= 1'b0;
      rsp_rdata   <= '0;
      rsp_x0      <= 1'b0;
      rsp_x1      <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      ie <= cfg_ie;
      if (accept) begin
        a           <= cmd_a;
        w           <= cmd_w;
        tim         <= cmd_tim;
        d_out       <= cmd_wdata;
        d_oe        <= cmd_w;
        rsp_rdata   <= '0;
        rsp_x0      <= 1'b0;
        rsp_x1      <= 1'b0;
        rsp_timeout <= 1'b0;
      end
      if (capture) begin
        rsp_x0 <= x0;
        rsp_x1 <= x1;
        if (!w) rsp_rdata <= d_in;
      end
      if (timeout_hit) begin
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
      if (exit_release) d_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm2201_bus_cycle_initiator.sv
// Bench for sm2201_bus_cycle_initiator: directed and randomized bus cycles against a cycle-count model.
module tb_sm2201_bus_cycle_initiator;

  localparam int DW    = 16;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;
  localparam int TO    = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_a = '0;
  logic          cmd_w = 1'b0;
  logic          cmd_tim = 1'b0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cfg_ie = 1'b0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_x0, rsp_x1, rsp_timeout;
  logic [1:0]    a;
  logic          w, sel, tim, ie, d_oe;
  logic [DW-1:0] d_out;
  logic          rdy = 1'b0;
  logic          x0 = 1'b0;
  logic          x1 = 1'b0;
  logic [DW-1:0] d_in = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sm2201_bus_cycle_initiator #(
    .DATA_WIDTH(DW), .SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_w(cmd_w), .cmd_tim(cmd_tim), .cmd_wdata(cmd_wdata),
    .cfg_ie(cfg_ie), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_x0(rsp_x0), .rsp_x1(rsp_x1), .rsp_timeout(rsp_timeout),
    .a(a), .w(w), .sel(sel), .tim(tim), .ie(ie), .d_out(d_out), .d_oe(d_oe),
    .rdy(rdy), .x0(x0), .x1(x1), .d_in(d_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge after the response.
  // rdly: strobe clocks with rdy low before rdy rises (>=TO never rises).
  // fdly: release clocks rdy stays high after capture (>=TO stuck high).
  task automatic run_txn(input logic [1:0] ta, input logic tw, input logic ttim,
                         input logic [DW-1:0] twd, input logic [DW-1:0] din,
                         input logic tx0, input logic tx1, input int rdly, input int fdly,
                         input logic pre_rdy, input logic keep);
    int  sel_high, rel, k_rsp, j;
    bit  strobe_to, to;
    logic exp_sel, exp_rdy;
    strobe_to = (rdly >= TO);
    sel_high  = strobe_to ? TO : rdly + 1;
    if (strobe_to)      rel = HOLD;
    else if (fdly >= TO) rel = TO;
    else                rel = (fdly + 1 > HOLD) ? fdly + 1 : HOLD;
    to    = strobe_to || (fdly >= TO);
    k_rsp = SETUP + 1 + sel_high + rel;

    chk("ready_before_accept", 32'(cmd_ready), 32'(1'b1));
    cmd_a = ta; cmd_w = tw; cmd_tim = ttim; cmd_wdata = twd; cmd_valid = 1'b1;
    d_in = din; x0 = tx0; x1 = tx1; rdy = pre_rdy;

    for (int k = 1; k <= k_rsp + 1; k++) begin
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
      exp_sel = (k >= SETUP + 1) && (k <= SETUP + sel_high);
      chk("sel", 32'(sel), 32'(exp_sel));
      chk("a", 32'(a), 32'(ta));
      chk("w", 32'(w), 32'(tw));
      chk("rsp_valid", 32'(rsp_valid), 32'(k == k_rsp));
      if (k <= k_rsp) begin
        chk("tim", 32'(tim), 32'(ttim));
        chk("cmd_ready_busy", 32'(cmd_ready), 32'(1'b0));
        chk("d_oe", 32'(d_oe), 32'((k < k_rsp) ? tw : 1'b0));
        if (tw) chk("d_out", 32'(d_out), 32'(twd));
      end else begin
        chk("cmd_ready_after", 32'(cmd_ready), 32'(1'b1));
      end
      if (k == k_rsp) begin
        chk("rsp_rdata", 32'(rsp_rdata), 32'((tw || to) ? 16'h0000 : din));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(to));
        if (!strobe_to) begin
          chk("rsp_x0", 32'(rsp_x0), 32'(tx0));
          chk("rsp_x1", 32'(rsp_x1), 32'(tx1));
        end
      end
      // automate model: rdy for the edge that follows this falling edge
      if (k < SETUP + 1) begin
        exp_rdy = pre_rdy;
      end else if (k <= SETUP + sel_high) begin
        j = k - SETUP - 1;
        exp_rdy = (j >= rdly);
      end else if (k <= SETUP + sel_high + rel) begin
        j = k - SETUP - 1 - sel_high;
        exp_rdy = !strobe_to && (j < fdly);
      end else begin
        exp_rdy = 1'b0;
      end
      rdy = exp_rdy;
    end
  endtask

  initial begin
    logic          v, prev;
    logic [1:0]    ra;
    logic          rw, rt, rx0, rx1, rp;
    logic [DW-1:0] rwd, rdin;
    int            r, f, rd, fd;

    // reset state
    @(negedge clk);
    chk("rst_sel", 32'(sel), 32'(1'b0));
    chk("rst_a", 32'(a), 32'(2'b00));
    chk("rst_d_oe", 32'(d_oe), 32'(1'b0));
    chk("rst_d_out", 32'(d_out), 32'(16'h0000));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("rst_ie", 32'(ie), 32'(1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1'b1));

    // ie follows cfg_ie one clock later
    prev = cfg_ie;
    for (int i = 0; i < 8; i++) begin
      v = 1'($urandom);
      cfg_ie = v;
      #1 chk("ie_not_yet", 32'(ie), 32'(prev));
      @(negedge clk);
      chk("ie_follow", 32'(ie), 32'(v));
      prev = v;
    end

    // read, rdy three clocks after sel
    run_txn(2'd2, 1'b0, 1'b0, 16'h0000, 16'hA5C3, 1'b1, 1'b0, 3, 0, 1'b0, 1'b0);
    // write, minimum cycle, with rdy already high in IDLE/SETUP
    run_txn(2'd1, 1'b1, 1'b1, 16'h1234, 16'hFFFF, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0);
    // strobe timeout, then a normal command
    run_txn(2'd0, 1'b0, 1'b0, 16'h0000, 16'h5555, 1'b1, 1'b1, TO, 0, 1'b0, 1'b0);
    run_txn(2'd3, 1'b0, 1'b1, 16'h0000, 16'h0F0F, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
    // stuck rdy in release, and the last-chance rdy in both phases
    run_txn(2'd1, 1'b0, 1'b0, 16'h0000, 16'hC0DE, 1'b1, 1'b0, 0, TO, 1'b0, 1'b0);
    run_txn(2'd2, 1'b0, 1'b0, 16'h0000, 16'h8001, 1'b1, 1'b1, TO - 1, TO - 1, 1'b0, 1'b0);

    // reset while sel is high
    cmd_a = 2'd3; cmd_w = 1'b1; cmd_wdata = 16'hBEEF; cmd_valid = 1'b1; rdy = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_reset_sel", 32'(sel), 32'(1'b1));
    #2 reset = 1'b1;
    #1;
    chk("mid_reset_sel", 32'(sel), 32'(1'b0));
    chk("mid_reset_a", 32'(a), 32'(2'b00));
    chk("mid_reset_d_oe", 32'(d_oe), 32'(1'b0));
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_no_rsp", 32'(rsp_valid), 32'(1'b0));
      chk("post_reset_sel", 32'(sel), 32'(1'b0));
    end
    run_txn(2'd2, 1'b0, 1'b0, 16'h0000, 16'h7E57, 1'b1, 1'b1, 2, 1, 1'b0, 1'b0);

    // back-to-back with cmd_valid held high
    run_txn(2'd1, 1'b0, 1'b0, 16'h0000, 16'h1111, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    run_txn(2'd3, 1'b1, 1'b0, 16'h2222, 16'h0000, 1'b0, 1'b0, 1, 0, 1'b0, 1'b1);
    run_txn(2'd0, 1'b0, 1'b1, 16'h0000, 16'h3333, 1'b1, 1'b0, 0, 2, 1'b0, 1'b1);
    run_txn(2'd2, 1'b1, 1'b1, 16'h4444, 16'h0000, 1'b0, 1'b1, 2, 1, 1'b0, 1'b1);
    cmd_valid = 1'b0;

    // randomized commands
    for (int i = 0; i < 16; i++) begin
      ra   = 2'($urandom);
      rw   = 1'($urandom);
      rt   = 1'($urandom);
      rx0  = 1'($urandom);
      rx1  = 1'($urandom);
      rp   = 1'($urandom);
      rwd  = 16'($urandom);
      rdin = 16'($urandom);
      r = int'($urandom_range(0, 9));
      f = int'($urandom_range(0, 7));
      rd = (r < 7) ? r : ((r == 7) ? TO - 1 : TO + r);
      fd = (f < 5) ? f : ((f == 5) ? TO - 1 : TO);
      run_txn(ra, rw, rt, rwd, rdin, rx0, rx1, rd, fd, rp, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
